// File: rtl/alu_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the ALU operation sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DATA_W  = 4;
    localparam int FLAGS_W = 4;
    localparam int RES_W   = DATA_W + FLAGS_W;

    // Flag bit positions inside res_flags, giving the {N,Z,C,V} order.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : result_fifo
//  Description : Occupancy-counted result FIFO with a combinational head read.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    // Requests against a full/empty FIFO are dropped rather than corrupting state.
    assign w_push = push & (r_count != FULL_CNT);
    assign w_pop  = pop  & (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Drives an external ALU over three cycles and queues results.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [DATA_W-1:0] cmd_sel,
    input  logic              cmd_use_acc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] alu_sel,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_y,
    output logic [3:0]        res_flags,
    output logic [DATA_W-1:0] acc,
    output logic [7:0]        op_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t             r_state;
    logic [DATA_W-1:0]  r_alu_a;
    logic [DATA_W-1:0]  r_alu_b;
    logic [DATA_W-1:0]  r_alu_sel;
    logic [DATA_W-1:0]  r_acc;
    logic [7:0]         r_op_count;
    logic               r_ready_en;

    logic               w_cmd_ready;
    logic               w_push;
    logic [FLAGS_W-1:0] w_flags;
    logic [RES_W-1:0]   w_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [CNT_W-1:0]   w_fifo_count;

    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_N] = alu_n;
        w_flags[FLAG_Z] = alu_z;
        w_flags[FLAG_C] = alu_c;
        w_flags[FLAG_V] = alu_v;
    end

    // r_ready_en keeps cmd_ready low throughout reset and rises on the first edge after it.
    assign w_cmd_ready = r_ready_en && (r_state == ST_IDLE) && !w_fifo_full;
    assign w_push      = (r_state == ST_CAPTURE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_sel  <= '0;
            r_acc      <= '0;
            r_op_count <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && w_cmd_ready) begin
                        r_alu_a   <= cmd_use_acc ? r_acc : cmd_a;
                        r_alu_b   <= cmd_b;
                        r_alu_sel <= cmd_sel;
                        r_state   <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_acc      <= alu_y;
                    r_op_count <= r_op_count + 8'd1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data ({alu_y, w_flags}),
        .pop       (res_ready),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // A command is only taken with a free slot, so the CAPTURE push can never overflow.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        w_fifo_count <= CNT_W'(FIFO_DEPTH));

    assign cmd_ready = w_cmd_ready;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign res_valid = !w_fifo_empty;
    assign res_y     = w_head[RES_W-1:FLAGS_W];
    assign res_flags = w_head[FLAGS_W-1:0];
    assign acc       = r_acc;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Self-checking bench for alu_op_sequencer with an XOR stub ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic [3:0] cmd_sel = '0;
    logic       cmd_use_acc = 1'b0;
    logic [3:0] alu_a, alu_b, alu_sel, alu_y;
    logic       alu_n, alu_z, alu_c, alu_v;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_y, res_flags, acc;
    logic [7:0] op_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference-model state: results still owed to the consumer, in order.
    int         m_phase  = 0;
    int         m_occ    = 0;
    int         m_popped = 0;
    logic [3:0] m_acc    = '0;
    logic [3:0] m_pend   = '0;
    logic [7:0] m_count  = '0;
    logic [7:0] m_q [$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sel;
        logic       use_acc;
        logic [3:0] exp_alu_a;
        logic [3:0] exp_y;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t       vecs [6];
    logic [3:0] ra [5];

    always #5 clk = ~clk;

    assign alu_y = alu_a ^ alu_b;
    assign alu_n = alu_y[3];
    assign alu_z = (alu_y == 4'd0);
    assign alu_c = 1'b0;
    assign alu_v = 1'b0;

    alu_op_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_sel    (cmd_sel),
        .cmd_use_acc(cmd_use_acc),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_y      (alu_y),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .alu_c      (alu_c),
        .alu_v      (alu_v),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_y      (res_y),
        .res_flags  (res_flags),
        .acc        (acc),
        .op_count   (op_count)
    );

    function automatic logic [3:0] flags_of(input logic [3:0] y);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = y[3];
        f[FLAG_Z] = (y == 4'd0);
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Offer one command and return at the negedge after the accepting edge.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s, input logic u);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        cmd_a = a; cmd_b = b; cmd_sel = s; cmd_use_acc = u; cmd_valid = 1'b1;
        while (!ok && n < 20) begin
            #1;
            ok = cmd_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        chk("send_handshake", ok, 1);
    endtask

    task automatic pop_check(input string name, input logic [3:0] y);
        #1;
        chk({name, "_valid"}, res_valid, 1);
        chk({name, "_y"}, res_y, y);
        chk({name, "_flags"}, res_flags, flags_of(y));
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    // One clock of the transaction-level reference model against current inputs.
    task automatic model_step();
        bit         accept, pop;
        logic [3:0] aa, y;
        #1;
        chk("rnd_cmd_ready", cmd_ready, (m_phase == 0 && m_occ < DEPTH));
        chk("rnd_res_valid", res_valid, (m_occ > 0));
        if (m_occ > 0) chk("rnd_head", {res_y, res_flags}, m_q[0]);
        chk("rnd_acc", acc, m_acc);
        chk("rnd_op_count", op_count, m_count);
        accept = cmd_valid && (m_phase == 0) && (m_occ < DEPTH);
        pop    = res_ready && (m_occ > 0);
        aa     = cmd_use_acc ? m_acc : cmd_a;
        y      = aa ^ cmd_b;
        @(posedge clk);
        if (m_phase == 2) begin
            m_occ++;
            m_acc = m_pend;
            m_count++;
            m_phase = 0;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (accept) begin
            m_pend = y;
            m_q.push_back({y, flags_of(y)});
            m_phase = 1;
        end
        if (pop) begin
            m_occ--;
            void'(m_q.pop_front());
            m_popped++;
        end
        @(negedge clk);
    endtask

    task automatic run_random(input int ncmd, input bit rr_always);
        int issued;
        int cyc;
        issued = 0;
        cyc    = 0;
        while (issued < ncmd && cyc < ncmd * 10 + 50) begin
            cmd_valid   = ($urandom_range(0, 3) != 0);
            cmd_a       = 4'($urandom);
            cmd_b       = 4'($urandom);
            cmd_sel     = 4'($urandom);
            cmd_use_acc = 1'($urandom);
            res_ready   = rr_always ? 1'b1 : 1'($urandom_range(0, 1));
            if (cmd_valid && m_phase == 0 && m_occ < DEPTH) issued++;
            model_step();
            cyc++;
        end
        cmd_valid = 1'b0;
        chk("rnd_issued", issued, ncmd);
        res_ready = 1'b1;
        cyc = 0;
        while ((m_phase != 0 || m_occ != 0) && cyc < 40) begin
            model_step();
            cyc++;
        end
        res_ready = 1'b0;
        #1;
        chk("rnd_drained", res_valid, 0);
    endtask

    initial begin
        vecs[0] = '{4'd10, 4'd15, 4'd8, 1'b0, 4'd10, 4'd5,  4'b0000};
        vecs[1] = '{4'd9,  4'd5,  4'd2, 1'b1, 4'd5,  4'd0,  4'b0100};
        vecs[2] = '{4'd3,  4'd12, 4'd1, 1'b1, 4'd0,  4'd12, 4'b1000};
        vecs[3] = '{4'd7,  4'd7,  4'd3, 1'b0, 4'd7,  4'd0,  4'b0100};
        vecs[4] = '{4'd6,  4'd9,  4'd4, 1'b0, 4'd6,  4'd15, 4'b1000};
        vecs[5] = '{4'd0,  4'd15, 4'd5, 1'b1, 4'd15, 4'd0,  4'b0100};
        ra      = '{4'd1, 4'd2, 4'd12, 4'd4, 4'd5};

        // Reset values
        @(negedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_y", res_y, 0);
        chk("rst_res_flags", res_flags, 0);
        chk("rst_acc", acc, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", alu_sel, 0);
        #3 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_first_edge", cmd_ready, 1);

        // Table-driven single operations
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].use_acc);
            chk("vec_alu_a", alu_a, vecs[i].exp_alu_a);
            chk("vec_alu_b", alu_b, vecs[i].b);
            chk("vec_alu_sel", alu_sel, vecs[i].sel);
            wait_cycles(1);
            #1;
            chk("vec_not_yet_valid", res_valid, 0);
            wait_cycles(1);
            #1;
            chk("vec_acc", acc, vecs[i].exp_y);
            chk("vec_op_count", op_count, i + 1);
            chk("vec_flags_table", res_flags, vecs[i].exp_flags);
            pop_check("vec", vecs[i].exp_y);
        end

        // Back-pressure: four fill the FIFO, the fifth waits for a pop
        for (int i = 0; i < 4; i++) begin
            send(ra[i], 4'hC, 4'(i), 1'b0);
            wait_cycles(2);
        end
        cmd_a = ra[4]; cmd_b = 4'hC; cmd_sel = 4'd4; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
        repeat (4) begin
            #1;
            chk("ready_low_when_full", cmd_ready, 0);
            @(posedge clk);
            @(negedge clk);
        end
        pop_check("full_pop0", ra[0] ^ 4'hC);
        #1;
        chk("ready_after_pop", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("fifth_alu_a", alu_a, ra[4]);
        wait_cycles(2);
        for (int i = 1; i < 5; i++) pop_check("full_order", ra[i] ^ 4'hC);
        #1;
        chk("full_drained", res_valid, 0);

        // Pop coinciding with a CAPTURE push at occupancy 2
        send(4'd3, 4'd5, 4'd0, 1'b0);
        wait_cycles(2);
        send(4'd8, 4'd1, 4'd0, 1'b0);
        wait_cycles(2);
        send(4'd7, 4'd7, 4'd0, 1'b0);
        wait_cycles(1);
        #1;
        chk("concurrent_head", res_y, 4'd6);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        pop_check("concurrent_second", 4'd9);
        pop_check("concurrent_third", 4'd0);
        #1;
        chk("concurrent_drained", res_valid, 0);

        // Reset asserted while an operation is in DRIVE
        send(4'd1, 4'd2, 4'd0, 1'b0);
        wait_cycles(2);
        send(4'd4, 4'd4, 4'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_res_valid", res_valid, 0);
        chk("abort_acc", acc, 0);
        chk("abort_op_count", op_count, 0);
        chk("abort_cmd_ready", cmd_ready, 0);
        chk("abort_alu_a", alu_a, 0);
        #3 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_ready_first_edge", cmd_ready, 1);
        wait_cycles(3);
        #1;
        chk("abort_no_entry", res_valid, 0);
        chk("abort_op_count_held", op_count, 0);
        chk("abort_acc_held", acc, 0);
        chk("abort_res_y", res_y, 0);

        // Randomised run against the reference model
        m_phase = 0; m_occ = 0; m_popped = 0; m_acc = '0; m_count = '0;
        m_q.delete();
        run_random(256, 1'b1);
        chk("wrap_op_count", op_count, 0);
        chk("wrap_all_results", m_popped, 256);
        run_random(80, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
